// File: rtl/vga_frame_capture_if.sv
// Video-in / board-out bundle for vga_frame_capture.
// The video source drives sync and colour; the capture block returns the
// decoded board together with its status strobes.
interface vga_frame_capture_if #(
    parameter int BOARD_N = 64
);
    logic               hsync;
    logic               vsync;
    logic [1:0]         r;
    logic [1:0]         g;
    logic [1:0]         b;
    logic [BOARD_N-1:0] board;
    logic               frame_valid;
    logic               locked;
    logic               sync_err;

    // Video source: produces pixels, observes the captured board.
    modport master (
        output hsync, vsync, r, g, b,
        input  board, frame_valid, locked, sync_err
    );

    // Capture block: consumes pixels, produces the captured board.
    modport slave (
        input  hsync, vsync, r, g, b,
        output board, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: locks onto a 640x480 VGA stream and samples the centre
// pixel of every cell of a BOARD_W x BOARD_H grid. A cell is alive when its
// centre pixel is black. The shadow copy is published to board once per
// eligible frame (locked for the whole frame up to line V_ACTIVE).
// Optional feature: define CAPTURE_DIFF_EN to publish (and pulse frame_valid)
// only when the new board differs from the one already published.
// Video timing is parameterised; the defaults are the 640x480 values.
module vga_frame_capture #(
    parameter int CELL_SIZE    = 24,
    parameter int BOARD_W      = 8,
    parameter int BOARD_H      = 8,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_TOTAL      = 525
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_frame_capture_if.slave vid
);
    localparam int BOARD_N = BOARD_W * BOARD_H;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int X0      = (H_ACTIVE - CELL_SIZE * BOARD_W) / 2;
    localparam int Y0      = (V_ACTIVE - CELL_SIZE * BOARD_H) / 2;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC    = HW'(H_SYNC_START);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC    = VW'(V_SYNC_START);
    localparam logic [VW-1:0] V_CAPTURE = VW'(V_ACTIVE);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               hs_q, vs_q, hs_p, vs_p;
    logic [1:0]         r_q, g_q, b_q;
    logic [HW-1:0]      hcnt, hcnt_free;
    logic [VW-1:0]      vcnt, vcnt_free;
    logic               h_fall, v_fall, mismatch;
    logic               align_h, align_v, sync_err;
    logic               eligible, capture, load, alive;
    logic [BOARD_W-1:0] col_hit;
    logic [BOARD_H-1:0] row_hit;
    logic [BOARD_N-1:0] shadow, board_q;
    logic               frame_valid_q;

    // Register the raw video once; hs_p/vs_p keep the previous registered sync for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every flop is written with <= so all registers sample the same pre-edge values.
        if (!rst_n) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            hs_p <= 1'b1;
            vs_p <= 1'b1;
            r_q  <= 2'b00;
            g_q  <= 2'b00;
            b_q  <= 2'b00;
        end else begin
            hs_q <= vid.hsync;
            vs_q <= vid.vsync;
            hs_p <= hs_q;
            vs_p <= vs_q;
            r_q  <= vid.r;
            g_q  <= vid.g;
            b_q  <= vid.b;
        end
    end

    assign h_fall = hs_p & ~hs_q;
    assign v_fall = vs_p & ~vs_q;

    // A simultaneous fall is never valid; otherwise each fall must land where the counters already are.
    assign mismatch = (h_fall & v_fall)
                    | (h_fall & (hcnt != H_SYNC))
                    | (v_fall & ((hcnt != '0) | (vcnt != V_SYNC)));

    // Free-running next raster position.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        hcnt_free = hcnt + 1'b1;
        vcnt_free = vcnt;
        if (hcnt == H_LAST) begin
            hcnt_free = '0;
            vcnt_free = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
    end

    // Sync tracker next state: which counter realignment to apply and when to flag an error.
    always_comb begin
        state_nx = state;
        align_h  = 1'b0;
        align_v  = 1'b0;
        sync_err = 1'b0;
        unique case (state)
            SEARCH: begin
                if (v_fall && !h_fall) begin
                    align_v  = 1'b1;
                    state_nx = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (mismatch) begin
                    align_v = v_fall;
                    align_h = !v_fall;
                end else if (v_fall) begin
                    state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    sync_err = 1'b1;
                    state_nx = SEARCH;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    // Tracker state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_nx;
    end

    // Raster counters; an alignment defines the current cycle, so the register takes the following position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (align_v) begin
            hcnt <= HW'(1);
            vcnt <= V_SYNC;
        end else if (align_h) begin
            hcnt <= H_SYNC + 1'b1;
        end else begin
            hcnt <= hcnt_free;
            vcnt <= vcnt_free;
        end
    end

    // Cell-centre decode: one comparator per column and per row.
    always_comb begin
        for (int col = 0; col < BOARD_W; col++)
            col_hit[col] = (hcnt == HW'(X0 + CELL_SIZE * col + CELL_SIZE / 2));
        for (int row = 0; row < BOARD_H; row++)
            row_hit[row] = (vcnt == VW'(Y0 + CELL_SIZE * row + CELL_SIZE / 2));
    end

    assign alive = (r_q == 2'b00) && (g_q == 2'b00) && (b_q == 2'b00);

    // Shadow board: each cell is overwritten once per frame at its centre pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: shadow is a flop bank rather than a RAM, so it is reset and a reset always restarts from an all-dead board.
        if (!rst_n) begin
            shadow <= '0;
        end else begin
            for (int row = 0; row < BOARD_H; row++)
                for (int col = 0; col < BOARD_W; col++)
                    if (row_hit[row] && col_hit[col])
                        shadow[row * BOARD_W + col] <= alive;
        end
    end

    // Frame eligibility: armed at the frame origin while locked, cleared by any loss of lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           eligible <= 1'b0;
        else if (state != LOCKED || mismatch) eligible <= 1'b0;
        else if (hcnt == '0 && vcnt == '0)    eligible <= 1'b1;
    end

    assign capture = eligible && (state == LOCKED) && !mismatch
                  && (hcnt == '0) && (vcnt == V_CAPTURE);

`ifdef CAPTURE_DIFF_EN
    assign load = capture && (shadow != board_q);
`else
    assign load = capture;
`endif

    // Publish the shadow; frame_valid rises together with the new board.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= load;
            if (load) board_q <= shadow;
        end
    end

    assign vid.board       = board_q;
    assign vid.frame_valid = frame_valid_q;
    assign vid.locked      = (state == LOCKED);
    assign vid.sync_err    = sync_err;
endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a scaled raster (48x30 total, 32x24 active,
// 2-pixel cells, 8x8 board) so each frame is 1440 clocks.
// Board origin x0=(32-16)/2=8, y0=(24-16)/2=4; cell (row,col) centre is
// x=9+2*col, y=5+2*row; capture line is 24; vsync falls at line 26.
// Dead cells: centre pixel non-black, rest of the cell black.
// Alive cells: centre pixel black, rest of the cell grey.
module tb_vga_frame_capture;
    localparam int CS = 2;
    localparam int BW = 8;
    localparam int BH = 8;
    localparam int HA = 32;
    localparam int HS = 36;
    localparam int HT = 48;
    localparam int VA = 24;
    localparam int VS = 26;
    localparam int VT = 30;
    localparam int X0 = 8;
    localparam int Y0 = 4;
    localparam logic [5:0] GREY = 6'b101010;

    typedef enum logic [1:0] {EV_FRAME, EV_ERR, EV_LOCK_RISE, EV_LOCK_FALL} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [63:0] board;
        int          line;
        int          gap;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_frame_capture_if #(.BOARD_N(BW * BH)) vid ();

    vga_frame_capture #(
        .CELL_SIZE(CS), .BOARD_W(BW), .BOARD_H(BH),
        .H_ACTIVE(HA), .H_SYNC_START(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VS), .V_TOTAL(VT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (vid)
    );

    int          total = 0;
    int          bad   = 0;
    ev_t         exp_q[$];
    logic [63:0] model_board;
    logic [63:0] cur_pat;
    logic [5:0]  cur_dead;
    int          gx = 0;
    int          gy = 0;
    int          early_line = -1;
    int          dual_line  = -1;
    int          cyc = 0;
    int          last_err_cyc = -100;
    logic        locked_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void expect_ev(ev_kind_t k, logic [63:0] b, int line, int gap);
        ev_t e;
        e.kind  = k;
        e.board = b;
        e.line  = line;
        e.gap   = gap;
        exp_q.push_back(e);
    endfunction

    // Expected publication of pat at line VA of the coming frame.
    task automatic expect_capture(input logic [63:0] pat);
`ifdef CAPTURE_DIFF_EN
        if (pat != model_board) begin
            expect_ev(EV_FRAME, pat, VA, -1);
            model_board = pat;
        end
`else
        expect_ev(EV_FRAME, pat, VA, -1);
        model_board = pat;
`endif
    endtask

    function automatic logic [5:0] pixel_rgb(int x, int y);
        int  col, row;
        logic centre, live;
        if (x < X0 || x >= X0 + CS * BW || y < Y0 || y >= Y0 + CS * BH) return 6'b000000;
        col    = (x - X0) / CS;
        row    = (y - Y0) / CS;
        centre = ((x - X0) % CS == CS / 2) && ((y - Y0) % CS == CS / 2);
        live   = cur_pat[row * BW + col];
        if (centre) return live ? 6'b000000 : cur_dead;
        return live ? GREY : 6'b000000;
    endfunction

    // Video source: one pixel per clock, driven on the falling edge.
    task automatic run_lines(input int y_first, input int y_last);
        for (int y = y_first; y <= y_last; y++) begin
            for (int x = 0; x < HT; x++) begin
                @(negedge clk);
                gy = y;
                gx = x;
                vid.hsync = !((x >= HS && x < HS + 4) || (y == early_line && x == HS - 1)
                              || (y == dual_line && x < 4));
                vid.vsync = !(y >= VS && y < VS + 2);
                {vid.r, vid.g, vid.b} = pixel_rgb(x, y);
            end
        end
    endtask

    task automatic frame(input logic [63:0] pat, input logic [5:0] dead);
        cur_pat  = pat;
        cur_dead = dead;
        run_lines(0, VT - 1);
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected %s: line %0d board %h, nothing pending", k.name(), gy, vid.board);
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("%s event kind", e.kind.name()), 64'(k), 64'(e.kind));
        check($sformatf("%s line", e.kind.name()), 64'(gy), 64'(e.line));
        case (k)
            EV_FRAME:     check("published board", vid.board, e.board);
            EV_ERR:       check("locked during sync_err", 64'(vid.locked), 64'h1);
            EV_LOCK_FALL: if (e.gap >= 0)
                              check("cycles sync_err to locked low", 64'(cyc - last_err_cyc), 64'(e.gap));
            default: ;
        endcase
    endtask

    // Monitor: every DUT strobe or lock transition is matched against the expectation queue.
    always @(negedge clk) begin
        cyc++;
        if (vid.frame_valid === 1'b1) observe(EV_FRAME);
        if (vid.sync_err === 1'b1) begin
            observe(EV_ERR);
            last_err_cyc = cyc;
        end
        if (vid.locked === 1'b1 && !locked_prev) observe(EV_LOCK_RISE);
        if (vid.locked === 1'b0 && locked_prev)  observe(EV_LOCK_FALL);
        locked_prev = (vid.locked === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_board = '0;
        cur_pat     = '0;
        cur_dead    = GREY;
        vid.hsync   = 1'b1;
        vid.vsync   = 1'b1;
        vid.r       = 2'b00;
        vid.g       = 2'b00;
        vid.b       = 2'b00;

        repeat (3) @(negedge clk);
        check("reset board", vid.board, 64'h0);
        check("reset frame_valid", 64'(vid.frame_valid), 64'h0);
        check("reset locked", 64'(vid.locked), 64'h0);
        check("reset sync_err", 64'(vid.sync_err), 64'h0);
        rst_n = 1'b1;

        // All dead: acquire on the first vsync fall, lock on the second, publish in the next frame.
        frame(64'h0, GREY);
        expect_ev(EV_LOCK_RISE, '0, VS, -1);
        frame(64'h0, GREY);
        expect_capture(64'h0);
        frame(64'h0, GREY);

        // Cells 3,4,5 black.
        expect_capture(64'h38);
        frame(64'h38, GREY);

        // Only cell 63 (centre x=23, y=19); dead centres have only red set.
        expect_capture(64'h8000_0000_0000_0000);
        frame(64'h8000_0000_0000_0000, 6'b010000);

        // Mixed patterns; dead centres carry only blue, then only green.
        expect_capture(64'hA5C3_0F96_1234_8001);
        frame(64'hA5C3_0F96_1234_8001, 6'b000001);
        expect_capture(64'h0F0F_F0F0_3C3C_C3C3);
        frame(64'h0F0F_F0F0_3C3C_C3C3, 6'b000100);

        // hsync falls one clock early on line 10: error, unlock, board held.
        early_line = 10;
        expect_ev(EV_ERR, '0, 10, -1);
        expect_ev(EV_LOCK_FALL, '0, 10, 1);
        frame(64'hFFFF_0000_FFFF_0000, GREY);
        early_line = -1;
        check("board held after sync error", vid.board, model_board);
        expect_ev(EV_LOCK_RISE, '0, VS, -1);
        frame(64'h0000_0000_0000_1111, GREY);
        expect_capture(64'h8421_8421_8421_8421);
        frame(64'h8421_8421_8421_8421, GREY);

        // hsync and vsync fall together on line 26: the frame already published, then error.
        dual_line = VS;
        expect_capture(64'hDEAD_BEEF_0BAD_F00D);
        expect_ev(EV_ERR, '0, VS, -1);
        expect_ev(EV_LOCK_FALL, '0, VS, 1);
        frame(64'hDEAD_BEEF_0BAD_F00D, GREY);
        dual_line = -1;
        frame(64'h0, GREY);
        expect_ev(EV_LOCK_RISE, '0, VS, -1);
        frame(64'h0, GREY);

        // Reset in the middle of a frame: immediate clear, two vsync falls to relock.
        cur_pat  = 64'hFFFF_FFFF_FFFF_FFFF;
        cur_dead = GREY;
        run_lines(0, 11);
        expect_ev(EV_LOCK_FALL, '0, 11, -1);
        #2 rst_n = 1'b0;
        #1;
        check("board cleared by async reset", vid.board, 64'h0);
        check("locked cleared by async reset", 64'(vid.locked), 64'h0);
        check("frame_valid low in reset", 64'(vid.frame_valid), 64'h0);
        model_board = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_lines(12, VT - 1);
        expect_ev(EV_LOCK_RISE, '0, VS, -1);
        frame(64'h0123_4567_89AB_CDEF, GREY);
        expect_capture(64'h0123_4567_89AB_CDEF);
        frame(64'h0123_4567_89AB_CDEF, GREY);

        // Same pattern for three frames.
        for (int i = 0; i < 3; i++) begin
            expect_capture(64'h7E81_8181_8181_817E);
            frame(64'h7E81_8181_8181_817E, GREY);
        end

        run_lines(0, 1);
        check("events still pending", 64'(exp_q.size()), 64'h0);
        check("final board", vid.board, model_board);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
